// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store master: access sizes, FSM states and
// big-endian byte-lane offsets.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // Byte offset within a word; offset 0 is the most significant lane
    localparam logic [1:0] OFF_B0 = 2'd0;
    localparam logic [1:0] OFF_B1 = 2'd1;
    localparam logic [1:0] OFF_B2 = 2'd2;
    localparam logic [1:0] OFF_B3 = 2'd3;

endpackage

// File: rtl/lsu_lane_mux.sv
// Big-endian lane steering: extracts and extends a load value from a memory
// word and merges sub-word store data into that same word.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      off_i,
    input  logic [1:0]      size_i,
    input  logic            uns_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];
        load_o   = word_i;
        merge_o  = word_i;

        case (off_i)
            OFF_B0:  byte_sel = word_i[31:24];
            OFF_B1:  byte_sel = word_i[23:16];
            OFF_B2:  byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase

        case (size_i)
            SZ_BYTE: begin
                load_o = uns_i ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                case (off_i)
                    OFF_B0:  merge_o[31:24] = wdata_i[7:0];
                    OFF_B1:  merge_o[23:16] = wdata_i[7:0];
                    OFF_B2:  merge_o[15:8]  = wdata_i[7:0];
                    default: merge_o[7:0]   = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                load_o = uns_i ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
                if (off_i[1]) begin
                    merge_o[15:0] = wdata_i[15:0];
                end else begin
                    merge_o[31:16] = wdata_i[15:0];
                end
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// Data-memory initiator: one load/store at a time, big-endian word memory,
// sub-word stores as read-modify-write.
module lsu_master
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;

    logic              req_misal_c;
    logic              req_err_c;
    logic [1:0]        req_off_c;
    logic [XLEN-1:0]   load_val;
    logic [XLEN-1:0]   merge_val;

    // Request legality and the lane offset kept for the access
    always_comb begin
        req_misal_c = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        req_err_c   = (req_size == SZ_BAD) ||
                      (req_addr >= 32'(MEM_BYTES)) ||
                      (CHECK_ALIGN && req_misal_c);
        case (req_size)
            SZ_HALF: req_off_c = {req_addr[1], 1'b0};
            SZ_WORD: req_off_c = 2'b00;
            default: req_off_c = req_addr[1:0];
        endcase
    end

    lsu_lane_mux u_lane_mux (
        .word_i  (mem_rdata),
        .off_i   (off_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .wdata_i (wdata_q),
        .load_o  (load_val),
        .merge_o (merge_val)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_off_c;
                    wdata_d = req_wdata;
                    if (req_err_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        // Full-word stores need no read, so they skip straight to WR
                        if (req_we && (req_size == SZ_WORD)) begin
                            state_d     = WR;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d     = WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_val;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = load_val;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // Async reset also kills an in-flight write enable immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_lsu_master.sv
// Bench for lsu_master: directed vector table, hold/reset sequences, then
// random traffic against a byte-array memory model.
module tb_lsu_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mem [256] = '{default: 32'h0};
    logic [7:0]  ref_mem [1024];

    lsu_master dut (
        .clk          (clk),
        .rst          (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide memory: async read, write on rising edge
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    endtask

    // ---------------- reference model (byte-addressed, big-endian) ----------------
    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a >= 32'd1024) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a);
        int i;
        logic [31:0] v;
        i = int'(a);
        if (sz == 2'd0) begin
            v = {24'h0, ref_mem[i]};
            if (!uns && ref_mem[i] >= 8'h80) v = v - 32'h100;
        end else if (sz == 2'd1) begin
            v = {16'h0, ref_mem[i], ref_mem[i+1]};
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int i;
        int n;
        i = int'(a);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[i+k] = 8'(wd >> (8 * (n - 1 - k)));
    endtask

    function automatic int model_lat(input logic we, input logic [1:0] sz, input logic err);
        if (err) return 1;
        if (we && sz != 2'd2) return 3;
        return 2;
    endfunction

    // ---------------- one transaction: drive, time, count writes, handshake ----------------
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err,
                           output int lat, output int wecnt);
        @(negedge clk);
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
        req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;
        lat = 99; wecnt = 0; rd = 32'hDEAD_0000; err = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we) wecnt++;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; err = resp_err;
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd, exp_rd;
        logic err, exp_err;
        int lat, wecnt;
        exp_err = model_err(sz, addr);
        exp_rd  = (exp_err || we) ? 32'h0 : model_load(sz, uns, addr);
        run_req(we, sz, uns, addr, wd, rd, err, lat, wecnt);
        check("rnd_rdata", rd, exp_rd);
        check("rnd_err", 32'(err), 32'(exp_err));
        check("rnd_latency", 32'(lat), 32'(model_lat(we, sz, exp_err)));
        check("rnd_mem_we_cycles", 32'(wecnt), (we && !exp_err) ? 32'd1 : 32'd0);
        if (we && !exp_err) model_store(sz, addr, wd);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] rd;
        logic err;
        int lat, wecnt, cyc;
        logic saw;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h11223344, 32'h00000000, 1'b0, 2};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h11223344, 1'b0, 2};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h12,  32'h000000AA, 32'h00000000, 1'b0, 3};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1122AA44, 1'b0, 2};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h12,  32'h0,        32'hFFFFFFAA, 1'b0, 2};
        vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h12,  32'h0,        32'h000000AA, 1'b0, 2};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFFAA44, 1'b0, 2};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        32'h00001122, 1'b0, 2};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h11,  32'h0,        32'h00000000, 1'b1, 1};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h13,  32'h5555,     32'h00000000, 1'b1, 1};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 32'h10,  32'h66666666, 32'h00000000, 1'b1, 1};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h00000000, 1'b1, 1};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1122AA44, 1'b0, 2};

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            run_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                    rd, err, lat, wecnt);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_mem_we_cycles", i), 32'(wecnt),
                  (vecs[i].we && !vecs[i].err) ? 32'd1 : 32'd0);
            if (vecs[i].we && !vecs[i].err) model_store(vecs[i].sz, vecs[i].addr, vecs[i].wd);
            if (i == 0) check("mem_after_sw", mem[4], 32'h11223344);
        end
        check("mem_after_errors", mem[4], 32'h1122AA44);

        // Response held off: outputs stable, new requests ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 10 && !saw; c++) begin
            @(negedge clk);
            saw = resp_valid;
        end
        check("hold_resp_seen", 32'(saw), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        wecnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_we) wecnt++;
            check("hold_resp_valid", 32'(resp_valid), 32'd1);
            check("hold_resp_rdata", resp_rdata, 32'h1122AA44);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        check("hold_no_write", 32'(wecnt), 32'd0);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk);
        #1 check("hold_handshake_done", 32'(resp_valid), 32'd0);
        check("hold_mem_untouched", mem[8], model_load(2'd2, 1'b0, 32'h20));

        // Reset asserted during the write cycle of an SH
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h0000BEEF; resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        saw = 1'b0;
        cyc = 0;
        while (!saw && cyc < 6) begin
            @(negedge clk);
            saw = mem_we;
            cyc++;
        end
        check("sh_reached_wr", 32'(saw), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midwr_mem_we", 32'(mem_we), 32'd0);
        check("midwr_req_ready", 32'(req_ready), 32'd1);
        check("midwr_resp_valid", 32'(resp_valid), 32'd0);
        check("midwr_resp_rdata", resp_rdata, 32'd0);
        check("midwr_mem_addr", mem_addr, 32'd0);
        check("midwr_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("midwr_word_unchanged", mem[4], model_load(2'd2, 1'b0, 32'h10));
        rst_n = 1'b1;
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = ($urandom_range(0, 15) == 0) ? 32'(1020 + $urandom_range(0, 40))
                                              : 32'($urandom_range(0, 63));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            txn(1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
